// File: rtl/prio_resp_return.sv
// ============================================================================
// Module   : prio_resp_return
// Purpose  : Routes two ALU result streams into four per-port 4-entry FIFOs
//            and returns one registered response per port per cycle.
//            Optional macro PRIO_RESP_OVERFLOW_CHK_EN adds a sticky drop flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_resp_return (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        alu1_out_vld,
    input  logic [0:1]  alu1_out_req_id,
    input  logic [0:1]  alu1_out_resp,
    input  logic [0:31] alu1_out_data,
    input  logic        alu2_out_vld,
    input  logic [0:1]  alu2_out_req_id,
    input  logic [0:1]  alu2_out_resp,
    input  logic [0:31] alu2_out_data,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:3]  ret_port_full,
    output logic        ret_overflow_err
);

    localparam int C_NUM_PORTS = 4;

    logic [0:33] w_e1;
    logic [0:33] w_e2;

    assign w_e1 = {alu1_out_resp, alu1_out_data};
    assign w_e2 = {alu2_out_resp, alu2_out_data};

    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
        logic        w_push1;
        logic        w_push2;
        logic        w_pop;
        logic        w_drop;
        logic        w_wr1;
        logic        w_wr2;
        logic [1:0]  w_nwr;
        logic [2:0]  w_count_nxt;
        logic [0:33] w_out_nxt;
        logic [0:33] r_mem [4];
        logic [1:0]  r_rd_ptr;
        logic [1:0]  r_wr_ptr;
        logic [2:0]  r_count;
        logic [0:33] r_out;
        logic        r_full;

        assign w_push1 = alu1_out_vld && (alu1_out_req_id == 2'(p));
        assign w_push2 = alu2_out_vld && (alu2_out_req_id == 2'(p));
        assign w_pop   = (r_count != 3'd0);
        // Only a full queue hit by both ALUs overflows, since it pops one too.
        assign w_drop  = (r_count == 3'd4) && w_push1 && w_push2;
        // An empty queue forwards the oldest new entry straight to the output.
        assign w_wr1   = w_pop && w_push1;
        assign w_wr2   = w_push2 && (w_pop ? !w_drop : w_push1);
        assign w_nwr   = {1'b0, w_wr1} + {1'b0, w_wr2};
        assign w_count_nxt = r_count + {1'b0, w_nwr} - {2'b00, w_pop};

        always_comb begin
            w_out_nxt = '0;
            if (w_pop) begin
                w_out_nxt = r_mem[r_rd_ptr];
            end else if (w_push1) begin
                w_out_nxt = w_e1;
            end else if (w_push2) begin
                w_out_nxt = w_e2;
            end
            if (w_out_nxt[0:1] == 2'b00) begin
                w_out_nxt[2:33] = '0;
            end
        end

        always_ff @(posedge c_clk) begin
            if (reset) begin
                if (w_wr1) begin
                    r_mem[r_wr_ptr] <= w_e1;
                end
                if (w_wr2) begin
                    r_mem[r_wr_ptr + {1'b0, w_wr1}] <= w_e2;
                end
            end
        end

        always_ff @(posedge c_clk) begin
            if (!reset) begin
                r_rd_ptr <= 2'd0;
                r_wr_ptr <= 2'd0;
                r_count  <= 3'd0;
                r_out    <= '0;
                r_full   <= 1'b0;
            end else begin
                r_rd_ptr <= r_rd_ptr + {1'b0, w_pop};
                r_wr_ptr <= r_wr_ptr + w_nwr;
                r_count  <= w_count_nxt;
                r_out    <= w_out_nxt;
                r_full   <= (w_count_nxt >= 3'd3);
            end
        end
    end

    assign out_resp1 = g_port[0].r_out[0:1];
    assign out_resp2 = g_port[1].r_out[0:1];
    assign out_resp3 = g_port[2].r_out[0:1];
    assign out_resp4 = g_port[3].r_out[0:1];
    assign out_data1 = g_port[0].r_out[2:33];
    assign out_data2 = g_port[1].r_out[2:33];
    assign out_data3 = g_port[2].r_out[2:33];
    assign out_data4 = g_port[3].r_out[2:33];

    assign ret_port_full = {g_port[0].r_full, g_port[1].r_full,
                            g_port[2].r_full, g_port[3].r_full};

`ifdef PRIO_RESP_OVERFLOW_CHK_EN
    logic r_ovf;

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (g_port[0].w_drop || g_port[1].w_drop ||
                     g_port[2].w_drop || g_port[3].w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ret_overflow_err = r_ovf;
`else
    assign ret_overflow_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_resp_return.sv
// ============================================================================
// Module   : tb_prio_resp_return
// Purpose  : Directed vector bench for prio_resp_return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_resp_return;

`ifdef PRIO_RESP_OVERFLOW_CHK_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu1_out_vld, alu2_out_vld;
    logic [0:1]  alu1_out_req_id, alu1_out_resp, alu2_out_req_id, alu2_out_resp;
    logic [0:31] alu1_out_data, alu2_out_data;
    logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [0:31] out_data1, out_data2, out_data3, out_data4;
    logic [0:3]  ret_port_full;
    logic        ret_overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    prio_resp_return dut (
        .c_clk            (c_clk),
        .reset            (reset),
        .alu1_out_vld     (alu1_out_vld),
        .alu1_out_req_id  (alu1_out_req_id),
        .alu1_out_resp    (alu1_out_resp),
        .alu1_out_data    (alu1_out_data),
        .alu2_out_vld     (alu2_out_vld),
        .alu2_out_req_id  (alu2_out_req_id),
        .alu2_out_resp    (alu2_out_resp),
        .alu2_out_data    (alu2_out_data),
        .out_resp1        (out_resp1),
        .out_resp2        (out_resp2),
        .out_resp3        (out_resp3),
        .out_resp4        (out_resp4),
        .out_data1        (out_data1),
        .out_data2        (out_data2),
        .out_data3        (out_data3),
        .out_data4        (out_data4),
        .ret_port_full    (ret_port_full),
        .ret_overflow_err (ret_overflow_err)
    );

    always #5 c_clk = ~c_clk;

    // pa/pb: expected active port number 1..4 (0 = none)
    typedef struct packed {
        logic        v1;
        logic [1:0]  id1;
        logic [1:0]  r1;
        logic [31:0] d1;
        logic        v2;
        logic [1:0]  id2;
        logic [1:0]  r2;
        logic [31:0] d2;
        logic [2:0]  pa;
        logic [1:0]  ra;
        logic [31:0] da;
        logic [2:0]  pb;
        logic [1:0]  rb;
        logic [31:0] db;
        logic [3:0]  ef;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic v1, input logic [1:0] id1, input logic [1:0] r1, input logic [31:0] d1,
        input logic v2, input logic [1:0] id2, input logic [1:0] r2, input logic [31:0] d2,
        input logic [2:0] pa, input logic [1:0] ra, input logic [31:0] da,
        input logic [2:0] pb, input logic [1:0] rb, input logic [31:0] db,
        input logic [3:0] ef, input logic eo);
        vec_t v;
        v.v1 = v1; v.id1 = id1; v.r1 = r1; v.d1 = d1;
        v.v2 = v2; v.id2 = id2; v.r2 = r2; v.d2 = d2;
        v.pa = pa; v.ra = ra; v.da = da;
        v.pb = pb; v.rb = rb; v.db = db;
        v.ef = ef; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu1_out_vld = v.v1; alu1_out_req_id = v.id1; alu1_out_resp = v.r1; alu1_out_data = v.d1;
        alu2_out_vld = v.v2; alu2_out_req_id = v.id2; alu2_out_resp = v.r2; alu2_out_data = v.d2;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        logic [1:0]  er, ar;
        logic [31:0] ed, ad;
        for (int p = 1; p <= 4; p++) begin
            er = (p == int'(v.pa)) ? v.ra : (p == int'(v.pb)) ? v.rb : 2'b00;
            ed = (p == int'(v.pa)) ? v.da : (p == int'(v.pb)) ? v.db : 32'h0;
            case (p)
                1: begin ar = out_resp1; ad = out_data1; end
                2: begin ar = out_resp2; ad = out_data2; end
                3: begin ar = out_resp3; ad = out_data3; end
                default: begin ar = out_resp4; ad = out_data4; end
            endcase
            chk($sformatf("%s resp%0d", tag, p), 64'(ar), 64'(er));
            chk($sformatf("%s data%0d", tag, p), 64'(ad), 64'(ed));
        end
        chk($sformatf("%s full", tag), 64'(ret_port_full), 64'(v.ef));
        chk($sformatf("%s ovf", tag), 64'(ret_overflow_err), 64'(v.eo));
    endtask

    task automatic step(input string tag, input vec_t v);
        drive(v);
        @(posedge c_clk);
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        vec_t idle;
        idle = row(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 4'b0000, 0);

        tbl.push_back(idle);
        tbl.push_back(row(1,2,1,32'h5, 0,0,0,0, 3,1,32'h5, 0,0,0, 4'b0000, 0));
        tbl.push_back(idle);
        tbl.push_back(row(1,0,1,32'hA, 1,0,1,32'hB, 1,1,32'hA, 0,0,0, 4'b0000, 0));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 1,1,32'hB, 0,0,0, 4'b0000, 0));
        tbl.push_back(idle);
        tbl.push_back(row(1,1,1,32'h11, 1,3,1,32'h22, 2,1,32'h11, 4,1,32'h22, 4'b0000, 0));
        tbl.push_back(row(0,0,0,0, 1,2,3,32'hDEADBEEF, 3,3,32'hDEADBEEF, 0,0,0, 4'b0000, 0));
        // Dual pushes to port 1: queue grows by one per cycle, fifth pair overflows.
        tbl.push_back(row(1,0,1,32'h101, 1,0,2,32'h102, 1,1,32'h101, 0,0,0, 4'b0000, 0));
        tbl.push_back(row(1,0,1,32'h201, 1,0,2,32'h202, 1,2,32'h102, 0,0,0, 4'b0000, 0));
        tbl.push_back(row(1,0,1,32'h301, 1,0,2,32'h302, 1,1,32'h201, 0,0,0, 4'b1000, 0));
        tbl.push_back(row(1,0,1,32'h401, 1,0,2,32'h402, 1,2,32'h202, 0,0,0, 4'b1000, 0));
        tbl.push_back(row(1,0,1,32'h501, 1,0,2,32'h502, 1,1,32'h301, 0,0,0, 4'b1000, OVF));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 1,2,32'h302, 0,0,0, 4'b1000, OVF));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 1,1,32'h401, 0,0,0, 4'b0000, OVF));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 1,2,32'h402, 0,0,0, 4'b0000, OVF));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 1,1,32'h501, 0,0,0, 4'b0000, OVF));
        tbl.push_back(row(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 4'b0000, OVF));

        drive(idle);
        reset = 1'b0;
        repeat (2) @(posedge c_clk);
        #1;
        check_outs("reset", idle);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Three entries left queued on port 2, then reset with a push pending.
        step("fill0", row(1,1,1,32'h61, 1,1,1,32'h62, 2,1,32'h61, 0,0,0, 4'b0000, OVF));
        step("fill1", row(1,1,1,32'h71, 1,1,1,32'h72, 2,1,32'h62, 0,0,0, 4'b0000, OVF));
        step("fill2", row(1,1,1,32'h81, 1,1,1,32'h82, 2,1,32'h71, 0,0,0, 4'b0100, OVF));
        reset = 1'b0;
        step("midrst", row(1,1,1,32'h99, 0,0,0,0, 0,0,0, 0,0,0, 4'b0000, 0));
        reset = 1'b1;
        step("first", row(1,1,1,32'h55, 0,0,0,0, 2,1,32'h55, 0,0,0, 4'b0000, 0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("post%0d", i), idle);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
